// File: rtl/iccm_readback.sv
// Dumps ICCM words to the UART transmitter, LSB byte first, from address 0 until the
// END_WORD terminator (or the last address) has been sent.
//
// state  | meaning
// IDLE   | waiting for start_i
// REQ    | one-cycle ICCM read request at addr_o
// WAIT   | waiting for rvalid_i, then latch the word
// SEND   | tx_dv_o pulse with the current byte
// WAITTX | waiting for tx_done_i from the UART
// DONE   | one-cycle done_o pulse
module iccm_readback #(
  parameter int unsigned ADDR_W   = 14,
  parameter logic [31:0] END_WORD = 32'h00000FFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic              rvalid_i,
  input  logic [31:0]       rdata_i,
  output logic              tx_dv_o,
  output logic [7:0]        tx_byte_o,
  input  logic              tx_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   words_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    SEND   = 3'd3,
    WAITTX = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e      state_q;
  logic [31:0] word_q;
  logic [1:0]  byte_idx_q;
  logic [1:0]  next_idx;

  assign next_idx = byte_idx_q + 2'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      word_q     <= '0;
      byte_idx_q <= '0;
      req_o      <= 1'b0;
      addr_o     <= '0;
      tx_dv_o    <= 1'b0;
      tx_byte_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      words_o    <= '0;
    end else begin
      req_o   <= 1'b0;
      tx_dv_o <= 1'b0;
      done_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= REQ;
            req_o      <= 1'b1;
            busy_o     <= 1'b1;
            addr_o     <= '0;
            words_o    <= '0;
            byte_idx_q <= '0;
          end
        end
        REQ: state_q <= WAIT;
        WAIT: begin
          if (rvalid_i) begin
            word_q     <= rdata_i;
            byte_idx_q <= '0;
            tx_byte_o  <= rdata_i[7:0];
            tx_dv_o    <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: state_q <= WAITTX;
        WAITTX: begin
          if (tx_done_i) begin
            if (byte_idx_q != 2'd3) begin
              byte_idx_q <= next_idx;
              tx_byte_o  <= word_q[{next_idx, 3'b000} +: 8];
              tx_dv_o    <= 1'b1;
              state_q    <= SEND;
            end else begin
              words_o <= words_o + 1'b1;
              // Stop on the terminator or at the top of the address space; never wrap.
              if (word_q == END_WORD || addr_o == LAST_ADDR) begin
                done_o  <= 1'b1;
                state_q <= DONE;
              end else begin
                addr_o  <= addr_o + 1'b1;
                req_o   <= 1'b1;
                state_q <= REQ;
              end
            end
          end
        end
        DONE: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
